rsa_modexp_unit: RTL and testbench

RSA_MODEXP_UNIT -- requirements
Module: rsa_modexp_unit

---
 rtl/rsa_modexp_unit.sv | 119 +++++++++++
 tb/tb_rsa_modexp_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_unit.sv
// rsa_modexp_unit: constant-time modular exponentiation C = M^E mod N.
// Uses right-to-left binary exponentiation built on one shared interleaved
// shift-add modular multiplier that consumes one multiplier bit per active edge.
module rsa_modexp_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             en_rsa,
  input  logic             clear_rsa,
  input  logic [WIDTH-1:0] plain,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] encrypted,
  output logic             eoc_rsa_unit
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = WIDTH + 2;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRE, S_MUL_R, S_MUL_B, S_HOLD
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_m, r_e, r_n, r_r, r_b;
  logic [PW-1:0]    r_p;
  logic [IW-1:0]    r_cnt, r_idx;

  logic             w_active, w_last, w_abit;
  logic [WIDTH-1:0] w_a, w_bm, w_res;
  logic [PW-1:0]    w_n, w_p2, w_p2r, w_p3, w_p3r;

  // Multiplier operand selection and one shift-add reduction step
  always_comb begin
    w_active = ena & en_rsa;
    w_last   = (r_cnt == LAST);
    case (r_state)
      S_PRE:   begin w_a = r_m; w_bm = WIDTH'(1); end
      S_MUL_R: begin w_a = r_r; w_bm = r_b;       end
      default: begin w_a = r_b; w_bm = r_b;       end
    endcase
    w_abit = w_a[LAST - r_cnt];
    w_n    = {2'b00, r_n};
    w_p2   = r_p << 1;
    w_p2r  = (w_p2 >= w_n) ? (w_p2 - w_n) : w_p2;
    w_p3   = w_p2r + (w_abit ? {2'b00, w_bm} : '0);
    w_p3r  = (w_p3 >= w_n) ? (w_p3 - w_n) : w_p3;
    w_res  = w_p3r[WIDTH-1:0];
  end

  // Next-state logic; a low clear overrides every state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_LOAD;
      S_LOAD:  w_next = S_PRE;
      S_PRE:   if (w_last) w_next = S_MUL_R;
      S_MUL_R: if (w_last) w_next = S_MUL_B;
      S_MUL_B: if (w_last) w_next = (r_idx == LAST) ? S_HOLD : S_MUL_R;
      S_HOLD:  w_next = S_HOLD;
      default: w_next = S_IDLE;
    endcase
    if (!clear_rsa) w_next = S_IDLE;
  end

  // State register, advanced only on active edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_state <= S_IDLE;
    else if (w_active) r_state <= w_next;
  end

  // Datapath registers: operand latch, multiplier accumulator, result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m <= '0; r_e <= '0; r_n <= '0; r_r <= '0; r_b <= '0;
      r_p <= '0; r_cnt <= '0; r_idx <= '0;
      encrypted <= '0; eoc_rsa_unit <= 1'b0;
    end else if (w_active) begin
      if (!clear_rsa) begin
        eoc_rsa_unit <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_m <= plain; r_e <= exponent; r_n <= modulus;
            r_r <= WIDTH'(1); r_b <= '0;
            r_p <= '0; r_cnt <= '0; r_idx <= '0;
          end
          S_PRE, S_MUL_R, S_MUL_B: begin
            if (w_last) begin
              r_p   <= '0;
              r_cnt <= '0;
              if (r_state == S_PRE) r_b <= w_res;
              // R*B is always computed; only the commit depends on the exponent bit
              if (r_state == S_MUL_R && r_e[r_idx]) r_r <= w_res;
              if (r_state == S_MUL_B) begin
                r_b <= w_res;
                if (r_idx == LAST) begin
                  encrypted    <= (r_n < WIDTH'(2)) ? '0 : r_r;
                  eoc_rsa_unit <= 1'b1;
                end else begin
                  r_idx <= r_idx + 1'b1;
                end
              end
            end else begin
              r_p   <= w_p3r;
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Scoreboard bench for rsa_modexp_unit (WIDTH=8): stimulus pushes expected
// result/latency, an independent monitor pops on each eoc rising edge.
module tb_rsa_modexp_unit;

  logic       clk, rst, ena, en_rsa, clear_rsa;
  logic [7:0] plain, exponent, modulus, encrypted;
  logic       eoc_rsa_unit;

  rsa_modexp_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .en_rsa(en_rsa), .clear_rsa(clear_rsa),
    .plain(plain), .exponent(exponent), .modulus(modulus),
    .encrypted(encrypted), .eoc_rsa_unit(eoc_rsa_unit)
  );

  typedef struct {
    int enc;
    int start;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   tot = 0;
  int   model_enc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) tot++;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: repeated modular multiplication, E times
  function automatic int ref_modexp(input int m, input int e, input int n);
    longint r;
    if (n < 2) return 0;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * m) % n;
    return int'(r);
  endfunction

  // Monitor: on every eoc rising edge compare against the scoreboard head
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (eoc_rsa_unit === 1'b1 && prev !== 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_eoc", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", int'(encrypted), e.enc);
          chk("latency", tot - e.start + 1, e.lat);
        end
      end
      prev = eoc_rsa_unit;
    end
  end

  task automatic reset_pulse(input string name);
    #3 rst = 1'b1;
    #1;
    chk({name, "_enc"}, int'(encrypted), 0);
    chk({name, "_eoc"}, int'(eoc_rsa_unit), 0);
    @(negedge clk);
    rst = 1'b0;
    model_enc = 0;
  endtask

  // mode: 0 normal, 1 with stalls, 2 abort at edge 50, 3 reset mid-run
  task automatic do_run(input int m, input int e, input int n, input int mode);
    int k;
    int expv;
    exp_t ent;
    expv = ref_modexp(m, e, n);
    plain = 8'(m); exponent = 8'(e); modulus = 8'(n);
    clear_rsa = 1'b0;
    @(negedge clk);
    clear_rsa = 1'b1;
    if (mode < 2) begin
      ent.enc = expv; ent.start = tot + 1; ent.lat = (mode == 1) ? 153 : 138;
      sb.push_back(ent);
    end
    @(negedge clk);
    @(negedge clk);
    plain = 8'($urandom); exponent = 8'($urandom); modulus = 8'($urandom);
    if (mode == 1) begin
      repeat (20) @(negedge clk);
      ena = 1'b0;
      repeat (10) @(negedge clk);
      ena = 1'b1; en_rsa = 1'b0;
      repeat (5) @(negedge clk);
      en_rsa = 1'b1;
    end
    if (mode == 2) begin
      repeat (47) @(negedge clk);
      clear_rsa = 1'b0;
      repeat (200) @(negedge clk);
      chk("abort_eoc", int'(eoc_rsa_unit), 0);
      chk("abort_enc", int'(encrypted), model_enc);
      return;
    end
    if (mode == 3) begin
      repeat (60) @(negedge clk);
      reset_pulse("midrun_rst");
      return;
    end
    k = 0;
    while (eoc_rsa_unit !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (eoc_rsa_unit !== 1'b1) chk("eoc_timeout", 0, 1);
    model_enc = expv;
    repeat (4) @(negedge clk);
    chk("hold_eoc", int'(eoc_rsa_unit), 1);
    chk("hold_enc", int'(encrypted), expv);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; en_rsa = 1'b1; clear_rsa = 1'b0;
    plain = '0; exponent = '0; modulus = '0;
    #1;
    chk("reset_enc", int'(encrypted), 0);
    chk("reset_eoc", int'(eoc_rsa_unit), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_eoc", int'(eoc_rsa_unit), 0);

    do_run(88, 7, 187, 0);
    reset_pulse("hold_rst");
    do_run(11, 23, 187, 0);
    do_run(200, 1, 187, 0);
    do_run(200, 0, 187, 0);
    do_run(200, 0, 1, 0);
    do_run(7, 5, 0, 0);
    do_run(255, 255, 2, 0);
    do_run(88, 7, 187, 2);
    do_run(88, 7, 187, 0);
    do_run(88, 7, 187, 1);
    do_run(11, 23, 187, 3);
    do_run(11, 23, 187, 0);
    for (int i = 0; i < 8; i++)
      do_run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
